// File: rtl/lsu_mem_arbiter_if.sv
// Bus bundle for lsu_mem_arbiter: LSU lane request/response signals,
// the single-ported data memory handshake, and the watchdog error pulse.
interface lsu_mem_arbiter_if #(
  parameter int NUM_LANES = 2
);
  logic [NUM_LANES-1:0]    req_valid;
  logic [NUM_LANES-1:0]    req_is_load;
  logic [NUM_LANES*32-1:0] req_addr;
  logic [NUM_LANES*32-1:0] req_wdata;
  logic [NUM_LANES-1:0]    req_ready;
  logic [NUM_LANES-1:0]    resp_valid;
  logic [31:0]             resp_rdata;
  logic                    lsu_stall;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_resp_valid;
  logic [31:0]             mem_rdata;
  logic                    err_timeout;

  // Arbiter view: consumes lane requests, masters the memory bus.
  modport master (
    input  req_valid, req_is_load, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, lsu_stall,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output err_timeout
  );

  // Environment view: the LSU lanes plus the data memory.
  modport slave (
    output req_valid, req_is_load, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, lsu_stall,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  err_timeout
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin sharing of one single-ported data memory
// between NUM_LANES load/store lanes, one outstanding transaction at a time.
// Optional macro LSU_ARB_TIMEOUT_EN adds a response watchdog that completes a
// hung load with 32'hDEAD_BEEF and pulses err_timeout.
module lsu_mem_arbiter #(
  parameter int NUM_LANES      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_arbiter_if.master bus
);
  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t               state_reg, state_next;
  logic [LANE_W-1:0]    rr_ptr_reg;
  logic [LANE_W-1:0]    grant_idx;
  logic [NUM_LANES-1:0] grant;
  logic                 grant_found;
  logic                 accept;
  logic [NUM_LANES-1:0] lane_reg;
  logic                 is_load_reg;
  logic [31:0]          addr_reg;
  logic [31:0]          wdata_reg;
  logic [NUM_LANES-1:0] resp_valid_reg, resp_valid_next;
  logic [31:0]          resp_rdata_reg, resp_rdata_next;

  if (NUM_LANES < 2 || NUM_LANES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_param_check
    $error("lsu_mem_arbiter: NUM_LANES or TIMEOUT_CYCLES out of range");
  end

`ifdef LSU_ARB_TIMEOUT_EN
  localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);

  logic [WD_W-1:0] wd_reg;
  logic            err_timeout_reg;
  logic            timeout_hit;

  // The cycle that would bring the counter to TIMEOUT_CYCLES ends the wait.
  assign timeout_hit = (state_reg == WAIT_RESP) && !bus.mem_resp_valid &&
                       (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin search: first requesting lane at or above rr_ptr, with wrap.
  always_comb begin
    int                idx;
    logic [LANE_W-1:0] lane;
    idx         = 0;
    lane        = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      lane = LANE_W'(idx);
      if (!grant_found && bus.req_valid[lane]) begin
        grant_found = 1'b1;
        grant[lane] = 1'b1;
        grant_idx   = lane;
      end
    end
  end

  assign accept = (state_reg == IDLE) && grant_found;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, handshake outputs and the completion to register next cycle.
  always_comb begin
    state_next        = state_reg;
    bus.req_ready     = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    resp_valid_next   = '0;
    resp_rdata_next   = '0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = grant;
        if (grant_found) state_next = ISSUE;
      end
      ISSUE: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = !is_load_reg;
        if (bus.mem_req_ready) begin
          if (is_load_reg) begin
            state_next = WAIT_RESP;
          end else begin
            state_next      = IDLE;
            resp_valid_next = lane_reg;
          end
        end
      end
      WAIT_RESP: begin
        if (bus.mem_resp_valid) begin
          state_next      = IDLE;
          resp_valid_next = lane_reg;
          resp_rdata_next = bus.mem_rdata;
        end
`ifdef LSU_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next      = IDLE;
          resp_valid_next = lane_reg;
          resp_rdata_next = 32'hDEAD_BEEF;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted request, advance rr_ptr, register completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      lane_reg       <= '0;
      is_load_reg    <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_valid_reg <= '0;
      resp_rdata_reg <= '0;
    end else begin
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      if (accept) begin
        lane_reg    <= grant;
        is_load_reg <= bus.req_is_load[grant_idx];
        addr_reg    <= bus.req_addr[{grant_idx, 5'd0} +: 32];
        // Loads never drive write data onto the memory bus.
        wdata_reg   <= bus.req_is_load[grant_idx] ? 32'd0
                                                  : bus.req_wdata[{grant_idx, 5'd0} +: 32];
        rr_ptr_reg  <= (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + LANE_W'(1);
      end
    end
  end

`ifdef LSU_ARB_TIMEOUT_EN
  // Watchdog: zero outside WAIT_RESP, counts response-less WAIT_RESP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_reg          <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      err_timeout_reg <= timeout_hit;
      if (state_reg != WAIT_RESP)  wd_reg <= '0;
      else if (!bus.mem_resp_valid) wd_reg <= wd_reg + WD_W'(1);
    end
  end

  assign bus.err_timeout = err_timeout_reg;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = wdata_reg;
  assign bus.lsu_stall  = |(bus.req_valid & ~bus.req_ready);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Testbench for lsu_mem_arbiter: directed protocol scenarios, then randomized
// lane/memory traffic checked against a transaction-level reference model.
module tb_lsu_mem_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_arbiter_if #(.NUM_LANES(N)) bus ();

  lsu_mem_arbiter #(.NUM_LANES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input bit v, input bit ld,
                          input logic [31:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_is_load[i]        = ld;
    bus.req_addr[32*i +: 32]  = a;
    bus.req_wdata[32*i +: 32] = d;
  endtask

  task automatic clear_inputs();
    bus.req_valid      = '0;
    bus.req_is_load    = '0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic idle_outputs_check();
    check("idle_req_ready",  bus.req_ready, 0);
    check("idle_lsu_stall",  bus.lsu_stall, 0);
    check("idle_resp_valid", bus.resp_valid, 0);
    check("idle_resp_rdata", bus.resp_rdata, 0);
    check("idle_mem_valid",  bus.mem_req_valid, 0);
    check("idle_mem_we",     bus.mem_we, 0);
    check("idle_mem_addr",   bus.mem_addr, 0);
    check("idle_mem_wdata",  bus.mem_wdata, 0);
    check("idle_err",        bus.err_timeout, 0);
  endtask

  // ---------------- reference model for the random phase ----------------
  bit          pend [N];
  bit          p_ld [N];
  logic [31:0] p_a  [N];
  logic [31:0] p_d  [N];
  int          m_rr;
  bit          m_active, m_issued, m_due;
  int          m_lane, m_due_lane;
  bit          m_ld;
  logic [31:0] m_a, m_d, m_due_data;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bfm_mem [logic [31:0]];
  bit          b_busy;
  int          b_cnt;
  logic [31:0] b_data;

  task automatic run_random(input int cycles, input int req_pct, input int rdy_pct);
    for (int c = 0; c < cycles; c++) begin
      int             g;
      logic [N-1:0]   exp_ready, pendvec;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(99) < req_pct) begin
          pend[i] = 1'b1;
          p_ld[i] = 1'($urandom_range(1));
          p_a[i]  = 32'($urandom_range(15)) << 2;
          p_d[i]  = $urandom;
        end
        set_lane(i, pend[i], p_ld[i], p_a[i], p_ld[i] ? $urandom : p_d[i]);
      end
      bus.mem_req_ready  = ($urandom_range(99) < rdy_pct);
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = $urandom;
      if (b_busy) begin
        b_cnt--;
        if (b_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = b_data;
          b_busy             = 1'b0;
        end
      end else if ($urandom_range(7) == 0) begin
        bus.mem_resp_valid = 1'b1;   // stray response that must be ignored
      end
      #1;
      // expected grant: first pending lane from the model pointer upward
      g = -1;
      exp_ready = '0;
      pendvec   = '0;
      for (int i = 0; i < N; i++) pendvec[i] = pend[i];
      if (!m_active) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("rnd_req_ready", bus.req_ready, exp_ready);
      check("rnd_lsu_stall", bus.lsu_stall, |(pendvec & ~exp_ready));
      check("rnd_resp_valid", bus.resp_valid, m_due ? (64'd1 << m_due_lane) : 64'd0);
      if (m_due) check("rnd_resp_rdata", bus.resp_rdata, m_due_data);
      check("rnd_mem_valid", bus.mem_req_valid, m_active && !m_issued);
      check("rnd_err", bus.err_timeout, 0);
      if (m_active && !m_issued) begin
        check("rnd_mem_addr",  bus.mem_addr, m_a);
        check("rnd_mem_we",    bus.mem_we, !m_ld);
        check("rnd_mem_wdata", bus.mem_wdata, m_ld ? 32'd0 : m_d);
      end
      // memory behaviour, driven by what the DUT actually presents
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (bus.mem_we) begin
          bfm_mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          b_busy = 1'b1;
          b_cnt  = $urandom_range(1, 3);
          b_data = bfm_mem.exists(bus.mem_addr) ? bfm_mem[bus.mem_addr] : 32'd0;
        end
      end
      // advance the model across the coming clock edge
      m_due = 1'b0;
      if (!m_active) begin
        if (g >= 0) begin
          m_active = 1'b1;
          m_issued = 1'b0;
          m_lane   = g;
          m_ld     = p_ld[g];
          m_a      = p_a[g];
          m_d      = p_d[g];
          m_rr     = (g + 1) % N;
          pend[g]  = 1'b0;
        end
      end else if (!m_issued) begin
        if (bus.mem_req_ready) begin
          if (m_ld) begin
            m_issued = 1'b1;
          end else begin
            ref_mem[m_a] = m_d;
            m_due        = 1'b1;
            m_due_lane   = m_lane;
            m_due_data   = 32'd0;
            m_active     = 1'b0;
          end
        end
      end else if (bus.mem_resp_valid) begin
        m_due      = 1'b1;
        m_due_lane = m_lane;
        m_due_data = ref_mem.exists(m_a) ? ref_mem[m_a] : 32'd0;
        m_active   = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 idle_outputs_check();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      idle_outputs_check();
    end

    // single store, lane 0
    @(negedge clk);
    set_lane(0, 1, 0, 32'h100, 32'hCAFE_F00D);
    bus.mem_req_ready = 1'b1;
    #1 check("st_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    set_lane(0, 0, 0, 0, 0);
    #1;
    check("st_mem_valid", bus.mem_req_valid, 1);
    check("st_mem_we",    bus.mem_we, 1);
    check("st_mem_addr",  bus.mem_addr, 32'h100);
    check("st_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    check("st_early_resp", bus.resp_valid, 0);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    check("st_resp_valid", bus.resp_valid, 2'b01);
    check("st_resp_rdata", bus.resp_rdata, 0);
    check("st_mem_idle",   bus.mem_req_valid, 0);

    // single load, lane 1, memory stalls then answers 3 cycles after handshake
    @(negedge clk);
    set_lane(1, 1, 1, 32'h200, 32'h5555_AAAA);
    #1 check("ld_ready", bus.req_ready, 2'b10);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) set_lane(1, 0, 0, 0, 0);
      bus.mem_req_ready = (c == 3);
      #1;
      check("ld_mem_valid", bus.mem_req_valid, 1);
      check("ld_mem_addr",  bus.mem_addr, 32'h200);
      check("ld_mem_we",    bus.mem_we, 0);
      check("ld_mem_wdata", bus.mem_wdata, 0);
    end
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = (c == 6);
      bus.mem_rdata      = (c == 6) ? 32'h1234_5678 : 32'h0;
      #1;
      check("ld_wait_mem", bus.mem_req_valid, 0);
      check("ld_wait_resp", bus.resp_valid, 0);
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    #1;
    check("ld_resp_valid", bus.resp_valid, 2'b10);
    check("ld_resp_rdata", bus.resp_rdata, 32'h1234_5678);

    // both lanes requesting continuously, memory stalled 4 cycles
    @(negedge clk);
    set_lane(0, 1, 0, 32'h300, 32'h1111_1111);
    set_lane(1, 1, 0, 32'h304, 32'h2222_2222);
    #1;
    check("rr_grant0", bus.req_ready, 2'b01);
    check("rr_stall0", bus.lsu_stall, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.mem_req_ready = (c == 5);
      #1;
      check("rr_hold_addr",  bus.mem_addr, 32'h300);
      check("rr_hold_valid", bus.mem_req_valid, 1);
      check("rr_hold_stall", bus.lsu_stall, 1);
      check("rr_hold_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    check("rr_resp0",  bus.resp_valid, 2'b01);
    check("rr_grant1", bus.req_ready, 2'b10);
    check("rr_stall1", bus.lsu_stall, 1);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    check("rr_addr1",  bus.mem_addr, 32'h304);
    check("rr_wdata1", bus.mem_wdata, 32'h2222_2222);
    @(negedge clk);
    #1;
    check("rr_resp1",  bus.resp_valid, 2'b10);
    check("rr_grant2", bus.req_ready, 2'b01);
    clear_inputs();

    // reset during WAIT_RESP, then a stale memory response
    @(negedge clk);
    set_lane(0, 1, 1, 32'h400, 32'h0);
    bus.mem_req_ready = 1'b1;
    #1 check("rst_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    #1 check("rst_mem_valid", bus.mem_req_valid, 1);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1 check("rst_waiting", bus.mem_req_valid, 0);
    rst = 1'b1;
    #1 idle_outputs_check();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hABCD;
    #1 check("rst_stale_resp", bus.resp_valid, 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    set_lane(0, 1, 1, 32'h10, 0);
    set_lane(1, 1, 1, 32'h14, 0);
    #1;
    check("rst_no_resp", bus.resp_valid, 0);
    check("rst_rr_zero", bus.req_ready, 2'b01);
    clear_inputs();

`ifdef LSU_ARB_TIMEOUT_EN
    // load that never gets a response
    begin
      int  waits;
      bit  seen;
      @(negedge clk);
      set_lane(0, 1, 1, 32'h500, 0);
      bus.mem_req_ready = 1'b1;
      #1 check("to_ready", bus.req_ready, 2'b01);
      @(negedge clk);
      clear_inputs();
      bus.mem_req_ready = 1'b1;
      #1 check("to_mem_valid", bus.mem_req_valid, 1);
      waits = 0;
      seen  = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        if (bus.err_timeout) seen = 1'b1;
        else begin
          waits++;
          check("to_quiet_resp", bus.resp_valid, 0);
        end
      end
      check("to_seen",       seen, 1);
      check("to_wait_count", waits, TO);
      check("to_resp_valid", bus.resp_valid, 2'b01);
      check("to_resp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      #1 check("to_err_pulse", bus.err_timeout, 0);
    end
`endif

    // randomized traffic against the reference model
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_ld[i] = 1'b0; p_a[i] = '0; p_d[i] = '0;
    end
    m_rr = 0; m_active = 1'b0; m_issued = 1'b0; m_due = 1'b0;
    m_lane = 0; m_due_lane = 0; m_ld = 1'b0; m_a = '0; m_d = '0; m_due_data = '0;
    ref_mem.delete();
    bfm_mem.delete();
    b_busy = 1'b0; b_cnt = 0; b_data = '0;
    @(negedge clk);
    rst = 1'b0;
    run_random(300, 100, 50);
    run_random(1500, 33, 75);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
